// File: rtl/div_arbiter.sv
// Two-requester front end for a single shared divider: round-robin grant, one
// operation in flight, requester-0 flush, and a buffered response per owner.
module div_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_dividend_i,
  input  logic [31:0] req0_divisor_i,
  input  logic [2:0]  req0_op_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_dividend_i,
  input  logic [31:0] req1_divisor_i,
  input  logic [2:0]  req1_op_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_data_o,
  output logic        rsp0_err_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_data_o,
  output logic        rsp1_err_o,
  input  logic        flush0_i,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [2:0]  div_op_o,
  output logic        div_start_o,
  input  logic [31:0] div_result_i,
  input  logic        div_valid_i,
  output logic        div_ready_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, ABORT} state_t;

  state_t      state;
  logic        last_served;
  logic        owner;
  logic [31:0] dividend_q;
  logic [31:0] divisor_q;
  logic [2:0]  op_q;
  logic [31:0] result_q;
  logic        err_q;

  logic        req0_eligible;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        flush_own;
  logic        owner_rsp_ready;
  logic [31:0] sel_dividend;
  logic [31:0] sel_divisor;
  logic [2:0]  sel_op;

  // A flushing requester 0 is treated as not requesting, so requester 1 may win.
  always_comb begin
    req0_eligible   = req0_valid_i & ~flush0_i;
    grant0          = req0_eligible & (~req1_valid_i | last_served);
    grant1          = req1_valid_i & (~req0_eligible | ~last_served);
    req0_ready_o    = (state == IDLE) & ~rst & grant0;
    req1_ready_o    = (state == IDLE) & ~rst & grant1;
    accept          = req0_ready_o | req1_ready_o;
    flush_own       = flush0_i & ~owner;
    owner_rsp_ready = owner ? rsp1_ready_i : rsp0_ready_i;
    sel_dividend    = req1_ready_o ? req1_dividend_i : req0_dividend_i;
    sel_divisor     = req1_ready_o ? req1_divisor_i  : req0_divisor_i;
    sel_op          = req1_ready_o ? req1_op_i       : req0_op_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b1;
      owner       <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      op_q        <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= req1_ready_o;
            dividend_q <= sel_dividend;
            divisor_q  <= sel_divisor;
            op_q       <= sel_op;
            // Non-divide funct3 values are answered locally with an error.
            if (sel_op[2]) begin
              state <= ISSUE;
            end else begin
              result_q <= '0;
              err_q    <= 1'b1;
              state    <= RESP;
            end
          end
        end
        ISSUE: begin
          if (flush_own) begin
            state <= ABORT;
          end else if (div_valid_i) begin
            result_q <= div_result_i;
            err_q    <= 1'b0;
            state    <= RESP;
          end
        end
        ABORT: state <= IDLE;
        RESP: begin
          if (flush_own) begin
            state <= IDLE;
          end else if (owner_rsp_ready) begin
            last_served <= owner;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    div_start_o    = (state == ISSUE);
    div_ready_o    = (state == ISSUE);
    div_dividend_o = div_start_o ? dividend_q : '0;
    div_divisor_o  = div_start_o ? divisor_q  : '0;
    div_op_o       = div_start_o ? op_q       : '0;
    rsp0_valid_o   = (state == RESP) & ~owner;
    rsp1_valid_o   = (state == RESP) & owner;
    rsp0_data_o    = rsp0_valid_o ? result_q : '0;
    rsp1_data_o    = rsp1_valid_o ? result_q : '0;
    rsp0_err_o     = rsp0_valid_o & err_q;
    rsp1_err_o     = rsp1_valid_o & err_q;
    busy_o         = (state != IDLE);
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed and randomized checks of div_arbiter against a transaction-level
// model; the bench also plays the shared divider using RISC-V division rules.
module tb_div_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_dividend_i, req0_divisor_i, req1_dividend_i, req1_divisor_i;
  logic [2:0]  req0_op_i, req1_op_i;
  logic        rsp0_valid_o, rsp1_valid_o, rsp0_ready_i, rsp1_ready_i;
  logic [31:0] rsp0_data_o, rsp1_data_o;
  logic        rsp0_err_o, rsp1_err_o;
  logic        flush0_i;
  logic [31:0] div_dividend_o, div_divisor_o, div_result_i;
  logic [2:0]  div_op_o;
  logic        div_start_o, div_valid_i, div_ready_o, busy_o;

  int n_vec  = 0;
  int n_miss = 0;
  bit check_en = 1'b0;

  // Model: is an operation held, is it waiting on the divider, is a response
  // pending, or is the one dead cycle after a flush being served.
  bit          m_busy, m_at_div, m_resp, m_abort, m_owner, m_last, m_err;
  logic [31:0] m_a, m_b, m_data;
  logic [2:0]  m_op;

  always #5 clk = ~clk;

  div_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_dividend_i(req0_dividend_i), .req0_divisor_i(req0_divisor_i), .req0_op_i(req0_op_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_dividend_i(req1_dividend_i), .req1_divisor_i(req1_divisor_i), .req1_op_i(req1_op_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
    .rsp0_data_o(rsp0_data_o), .rsp0_err_o(rsp0_err_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
    .rsp1_data_o(rsp1_data_o), .rsp1_err_o(rsp1_err_o),
    .flush0_i(flush0_i),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o), .div_op_o(div_op_o),
    .div_start_o(div_start_o), .div_result_i(div_result_i), .div_valid_i(div_valid_i),
    .div_ready_o(div_ready_o), .busy_o(busy_o)
  );

  function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
      3'b111:  return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -1 when nobody may be accepted this cycle.
  function automatic int pick_winner();
    bit v0;
    v0 = req0_valid_i && !flush0_i;
    if (m_busy || rst) return -1;
    if (v0 && req1_valid_i) return m_last ? 0 : 1;
    if (v0) return 0;
    if (req1_valid_i) return 1;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      m_busy = 0; m_at_div = 0; m_resp = 0; m_abort = 0; m_last = 1;
    end else if (!m_busy) begin
      w = pick_winner();
      if (w >= 0) begin
        m_owner = (w == 1);
        m_a  = m_owner ? req1_dividend_i : req0_dividend_i;
        m_b  = m_owner ? req1_divisor_i  : req0_divisor_i;
        m_op = m_owner ? req1_op_i       : req0_op_i;
        m_busy = 1;
        if (m_op[2]) m_at_div = 1;
        else begin m_resp = 1; m_data = 0; m_err = 1; end
      end
    end else if (m_at_div) begin
      if (flush0_i && !m_owner) begin m_at_div = 0; m_abort = 1; end
      else if (div_valid_i) begin m_at_div = 0; m_resp = 1; m_data = div_result_i; m_err = 0; end
    end else if (m_abort) begin
      m_abort = 0; m_busy = 0;
    end else if (m_resp) begin
      if (flush0_i && !m_owner) begin m_resp = 0; m_busy = 0; end
      else if (m_owner ? rsp1_ready_i : rsp0_ready_i) begin
        m_resp = 0; m_busy = 0; m_last = m_owner;
      end
    end
  endtask

  task automatic compare_outputs();
    int w;
    w = pick_winner();
    check("req0_ready", 32'(req0_ready_o), 32'(w == 0));
    check("req1_ready", 32'(req1_ready_o), 32'(w == 1));
    check("busy", 32'(busy_o), 32'(m_busy));
    check("div_start", 32'(div_start_o), 32'(m_at_div));
    check("div_ready", 32'(div_ready_o), 32'(m_at_div));
    if (m_at_div) begin
      check("div_dividend", div_dividend_o, m_a);
      check("div_divisor", div_divisor_o, m_b);
      check("div_op", 32'(div_op_o), 32'(m_op));
    end else if (!m_busy) begin
      check("div_data_idle", div_dividend_o | div_divisor_o | 32'(div_op_o), 32'h0);
    end
    check("rsp0_valid", 32'(rsp0_valid_o), 32'(m_resp && !m_owner));
    check("rsp1_valid", 32'(rsp1_valid_o), 32'(m_resp && m_owner));
    if (m_resp) begin
      check("rsp_data", m_owner ? rsp1_data_o : rsp0_data_o, m_data);
      check("rsp_err", 32'(m_owner ? rsp1_err_o : rsp0_err_o), 32'(m_err));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) compare_outputs();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid_i = 0; req1_valid_i = 0; rsp0_ready_i = 0; rsp1_ready_i = 0;
    flush0_i = 0; div_valid_i = 0; div_result_i = 0;
    req0_dividend_i = 0; req0_divisor_i = 0; req0_op_i = 0;
    req1_dividend_i = 0; req1_divisor_i = 0; req1_op_i = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    check_en = 1;
    tick();
    rst = 0;
  endtask

  task automatic drive_req(input bit who, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (who) begin
      req1_valid_i = 1; req1_op_i = op; req1_dividend_i = a; req1_divisor_i = b;
    end else begin
      req0_valid_i = 1; req0_op_i = op; req0_dividend_i = a; req0_divisor_i = b;
    end
  endtask

  // Full operation with literal expectations; called at posedge+1.
  task automatic do_op(input bit who, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] exp_data, input bit exp_err);
    int waited;
    drive_req(who, op, a, b);
    rsp0_ready_i = 1; rsp1_ready_i = 1;
    waited = 0;
    @(negedge clk);
    while (!(who ? req1_ready_o : req0_ready_o) && waited < 20) begin
      tick();
      @(negedge clk);
      waited++;
    end
    check("grant", 32'(who ? req1_ready_o : req0_ready_o), 32'h1);
    tick();
    if (who) req1_valid_i = 0; else req0_valid_i = 0;
    if (waited >= 20) return;
    if (op[2]) begin
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        check("start_held", 32'(div_start_o), 32'h1);
        tick();
      end
      div_valid_i = 1;
      div_result_i = golden(op, a, b);
      @(negedge clk);
      check("start_at_result", 32'(div_start_o), 32'h1);
      tick();
      div_valid_i = 0;
    end
    @(negedge clk);
    check("rsp_valid", 32'(who ? rsp1_valid_o : rsp0_valid_o), 32'h1);
    check("rsp_data", who ? rsp1_data_o : rsp0_data_o, exp_data);
    check("rsp_err", 32'(who ? rsp1_err_o : rsp0_err_o), 32'(exp_err));
    check("start_after", 32'(div_start_o), 32'h0);
    tick();
  endtask

  function automatic logic [2:0] pick_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return {1'b1, 2'(r % 4)};
    return 3'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    idle_inputs();
    do_reset();
    @(negedge clk);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_start", 32'(div_start_o), 32'h0);
    check("reset_rsp", 32'({rsp0_valid_o, rsp1_valid_o}), 32'h0);
    tick();

    // DIV 100/7 with two wait cycles at the divider.
    do_op(0, 3'b100, 32'd100, 32'd7, 2, 32'd14, 0);

    // Simultaneous requests right after reset: requester 0 first.
    do_reset();
    drive_req(1, 3'b101, 32'd9, 32'd3);
    do_op(0, 3'b111, 32'd10, 32'd3, 1, 32'd1, 0);
    do_op(1, 3'b101, 32'd9, 32'd3, 0, 32'd3, 0);

    // REM -7/2 with a stalled consumer while requester 0 keeps asking.
    drive_req(1, 3'b110, 32'hFFFF_FFF9, 32'd2);
    rsp1_ready_i = 0;
    @(negedge clk);
    check("rem_grant", 32'(req1_ready_o), 32'h1);
    tick();
    req1_valid_i = 0;
    div_valid_i = 1;
    div_result_i = golden(3'b110, 32'hFFFF_FFF9, 32'd2);
    tick();
    div_valid_i = 0;
    drive_req(0, 3'b100, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", rsp1_data_o, 32'hFFFF_FFFF);
      check("stall_valid", 32'(rsp1_valid_o), 32'h1);
      check("stall_busy", 32'(busy_o), 32'h1);
      check("stall_req0", 32'(req0_ready_o), 32'h0);
      tick();
    end
    rsp1_ready_i = 1;
    req0_valid_i = 0;
    tick();

    // Invalid funct3 answered locally.
    do_op(0, 3'b000, 32'd5, 32'd1, 0, 32'h0, 1);

    // Flush while requester 0 is at the divider, then DIVU by zero.
    drive_req(0, 3'b100, 32'd50, 32'd5);
    tick();
    req0_valid_i = 0;
    tick();
    flush0_i = 1;
    div_valid_i = 1;
    div_result_i = 32'd10;
    tick();
    flush0_i = 0;
    div_valid_i = 0;
    @(negedge clk);
    check("abort_start", 32'(div_start_o), 32'h0);
    check("abort_busy", 32'(busy_o), 32'h1);
    check("abort_rsp", 32'(rsp0_valid_o), 32'h0);
    tick();
    @(negedge clk);
    check("abort_idle", 32'(busy_o), 32'h0);
    check("abort_no_rsp", 32'(rsp0_valid_o), 32'h0);
    tick();
    do_op(1, 3'b101, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 0);

    // Reset in the middle of a divide.
    drive_req(1, 3'b101, 32'd7, 32'd1);
    tick();
    req1_valid_i = 0;
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("rst_start", 32'(div_start_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_rsp", 32'(rsp1_valid_o), 32'h0);
    tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      req0_valid_i = 1'($urandom_range(0, 1));
      req1_valid_i = 1'($urandom_range(0, 1));
      req0_op_i = pick_op();
      req1_op_i = pick_op();
      req0_dividend_i = pick_operand();
      req0_divisor_i  = pick_operand();
      req1_dividend_i = pick_operand();
      req1_divisor_i  = pick_operand();
      rsp0_ready_i = ($urandom_range(0, 9) < 6);
      rsp1_ready_i = ($urandom_range(0, 9) < 6);
      flush0_i = ($urandom_range(0, 11) == 0);
      div_valid_i = ($urandom_range(0, 2) == 0);
      div_result_i = m_at_div ? golden(m_op, m_a, m_b) : 32'($urandom);
      tick();
    end

    rst = 0;
    idle_inputs();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have ports reqN_valid_i, input, 1, N=0,1: requester N presents an operation.
REQ-004 SHALL have ports reqN_ready_o, output, 1: operation accepted on valid&ready.
REQ-005 SHALL have ports reqN_dividend_i / reqN_divisor_i, input, 32 each: operands.
REQ-006 SHALL have ports reqN_op_i, input, 3: funct3 (DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111).
REQ-007 SHALL have ports rspN_valid_o, output, 1; rspN_ready_i, input, 1; rspN_data_o, output, 32; rspN_err_o, output, 1: response channel per requester.
REQ-008 SHALL have port flush0_i, input, 1: kill requester-0 operation (pipeline flush).
REQ-009 SHALL have ports div_dividend_o, div_divisor_o (output, 32), div_op_o (output, 3), div_start_o (output, 1): to shared divider.
REQ-010 SHALL have ports div_result_i (input, 32), div_valid_i (input, 1), div_ready_o (output, 1): divider result handshake.
REQ-011 SHALL have port busy_o, output, 1: high in any state except IDLE.

Function
REQ-012 SHALL implement FSM IDLE, ISSUE, RESP, ABORT; one operation in flight.
REQ-013 In IDLE, reqN_ready_o SHALL be 1 only for the granted requester; other states: both 0.
REQ-014 Arbitration SHALL be round-robin: single requester wins; both valid -> requester not served last; last-served pointer resets to 1 (req0 wins first).
REQ-015 On accept, operands, op and owner SHALL be latched; next state ISSUE (valid op) or RESP (invalid op).
REQ-016 Invalid op (bit2=0) SHALL never reach divider; response data 32'h0, err=1, one cycle after accept.
REQ-017 In ISSUE, div_start_o SHALL be 1 and div_* operand/op outputs SHALL equal latched values, held stable every cycle until div result handshake; first start cycle is the cycle after accept.
REQ-018 In ISSUE, div_ready_o SHALL be 1; on div_valid_i=1, div_result_i SHALL be captured into response buffer, state -> RESP, div_start_o 0 from next cycle.
REQ-019 In RESP, rsp<owner>_valid_o SHALL be 1 with buffered data, err per REQ-016 (else 0); other requester's rsp_valid 0; data held stable until rsp_ready_i.
REQ-020 On rsp handshake, state -> IDLE, last-served pointer := owner; new accept earliest the following cycle.
REQ-021 Outside ISSUE, div_start_o and div_ready_o SHALL be 0; div_* data outputs 0 in IDLE.
REQ-022 flush0_i with owner=0 in ISSUE SHALL -> ABORT: div_start_o 0 for exactly one cycle, then IDLE; no response, pointer unchanged.
REQ-023 flush0_i with owner=0 in RESP SHALL discard response, -> IDLE next cycle.
REQ-024 flush0_i SHALL be ignored when owner=1 or in IDLE; a same-cycle req0 accept with flush0_i=1 SHALL NOT occur (req0_ready_o forced 0 while flush0_i=1).
REQ-025 div_valid_i coinciding with flush in ISSUE: flush wins, result dropped.
REQ-026 Divide-by-zero and overflow SHALL be passed through unmodified from divider; err=0.

Reset
REQ-027 rst=1 SHALL force IDLE, pointer=1, buffer=0, all outputs 0 except reqN_ready_o per REQ-013 after release; any in-flight operation abandoned, div_start_o 0 the cycle after rst sampled.
REQ-028 Reset SHALL take priority over flush and all handshakes.

Verification
REQ-029 req0 DIV 100/7, rsp0_ready=1 -> rsp0_data=14, err=0; div_start_o high from cycle after accept until div_valid.
REQ-030 req0 and req1 valid same cycle after reset (REMU 10/3, DIVU 9/3) -> req0 served first (data 1), then req1 (data 3).
REQ-031 req1 REM 0xFFFFFFF9/2 with rsp1_ready=0 for 5 cycles -> rsp1_data=0xFFFFFFFF held stable, busy_o=1, req0 not accepted.
REQ-032 req0 op=3'b000 -> rsp0_valid cycle after accept, data 0, err=1, div_start_o never asserted.
REQ-033 flush0_i during req0 ISSUE -> div_start_o low one cycle, no rsp0_valid, busy_o 0 two cycles after flush; subsequent req1 DIVU 5/0 -> 0xFFFFFFFF.
REQ-034 rst asserted mid-ISSUE -> next cycle div_start_o=0, busy_o=0, no response issued.
